// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the on-chip RAM controller and its arbiter.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int NUM_LANES  = 4;
    localparam int DEF_MEM_AW = 14;

    // Expands per-lane byte selects into a 32-bit data mask.
    function automatic logic [31:0] lane_mask(input logic [NUM_LANES-1:0] sel);
        logic [31:0] mask;
        mask = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            mask[8*k +: 8] = {8{sel[k]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/mem_rr_arb.sv
// Two-way round-robin arbiter; last_grant doubles as the id of the port being served.
module mem_rr_arb
    import mem_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       last_grant
);

    always_comb begin
        grant = '0;
        if (req[PORT_I] && req[PORT_D]) begin
            if (last_grant == PORT_D) begin
                grant[PORT_I] = 1'b1;
            end else begin
                grant[PORT_D] = 1'b1;
            end
        end else begin
            grant = req;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= PORT_D;
        end else if (advance && (|grant)) begin
            last_grant <= grant[PORT_D] ? PORT_D : PORT_I;
        end
    end

endmodule

// File: rtl/mem_arb_ctrl.sv
// Shares the four byte-wide RAM banks between the instruction-fetch and data ports,
// running each access as IDLE -> ACCESS -> RESP with registered outputs.
module mem_arb_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int               MEM_AW  = DEF_MEM_AW,
    parameter logic [29-MEM_AW:0] BASE_HI = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [31:0]       i_adr,
    output logic [31:0]       i_dat,
    output logic              i_ack,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_sel,
    input  logic [31:0]       d_adr,
    input  logic [31:0]       d_dat_i,
    output logic [31:0]       d_dat_o,
    output logic              d_ack,
    output logic              d_err,
    output logic [MEM_AW-1:0] mem_adr,
    output logic [31:0]       mem_dat_o,
    input  logic [31:0]       mem_dat_i,
    output logic [3:0]        mem_en,
    output logic [3:0]        mem_we
);

    state_t      state;
    logic [1:0]  req;
    logic [1:0]  grant;
    logic        last_grant;
    logic        we_r;
    logic [3:0]  sel_r;

    logic        g_port;
    logic [31:0] g_adr;
    logic        g_we;
    logic [3:0]  g_sel;
    logic        g_err;

    assign req[PORT_I] = i_req;
    assign req[PORT_D] = d_req;

    mem_rr_arb u_arb (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .advance    (state == IDLE),
        .grant      (grant),
        .last_grant (last_grant)
    );

    // Attributes of the winning request; instruction fetches are always full-word reads.
    always_comb begin
        g_port = grant[PORT_D] ? PORT_D : PORT_I;
        g_adr  = (g_port == PORT_D) ? d_adr : i_adr;
        g_we   = (g_port == PORT_D) && d_we;
        g_sel  = (g_port == PORT_D) ? d_sel : 4'hF;
        g_err  = (g_adr[31:MEM_AW+2] != BASE_HI) ||
                 ((g_port == PORT_I) && (g_adr[1:0] != 2'b00));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            we_r      <= 1'b0;
            sel_r     <= '0;
            mem_adr   <= '0;
            mem_dat_o <= '0;
            mem_en    <= '0;
            mem_we    <= '0;
            i_ack     <= 1'b0;
            i_err     <= 1'b0;
            i_dat     <= '0;
            d_ack     <= 1'b0;
            d_err     <= 1'b0;
            d_dat_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        we_r  <= g_we;
                        sel_r <= g_sel;
                        if (g_err) begin
                            state <= RESP;
                            if (g_port == PORT_D) begin
                                d_ack <= 1'b1;
                                d_err <= 1'b1;
                            end else begin
                                i_ack <= 1'b1;
                                i_err <= 1'b1;
                            end
                        end else begin
                            state     <= ACCESS;
                            mem_adr   <= g_adr[MEM_AW+1:2];
                            mem_en    <= g_sel;
                            mem_we    <= g_we ? g_sel : 4'h0;
                            mem_dat_o <= g_we ? d_dat_i : 32'h0;
                        end
                    end
                end
                ACCESS: begin
                    // Banks are released here so they are never driven outside ACCESS.
                    state     <= RESP;
                    mem_en    <= '0;
                    mem_we    <= '0;
                    mem_dat_o <= '0;
                    if (last_grant == PORT_D) begin
                        d_ack   <= 1'b1;
                        d_err   <= 1'b0;
                        d_dat_o <= we_r ? 32'h0 : (mem_dat_i & lane_mask(sel_r));
                    end else begin
                        i_ack <= 1'b1;
                        i_err <= 1'b0;
                        i_dat <= mem_dat_i;
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    i_ack   <= 1'b0;
                    i_err   <= 1'b0;
                    i_dat   <= '0;
                    d_ack   <= 1'b0;
                    d_err   <= 1'b0;
                    d_dat_o <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Self-checking bench for mem_arb_ctrl: vector table, arbitration and reset corner cases,
// with a byte-bank RAM model and a response scoreboard.
module tb_mem_arb_ctrl;
    import mem_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_adr;
    logic [31:0] i_dat;
    logic        i_ack;
    logic        i_err;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_sel;
    logic [31:0] d_adr;
    logic [31:0] d_dat_i;
    logic [31:0] d_dat_o;
    logic        d_ack;
    logic        d_err;
    logic [13:0] mem_adr;
    logic [31:0] mem_dat_o;
    logic [31:0] mem_dat_i;
    logic [3:0]  mem_en;
    logic [3:0]  mem_we;

    mem_arb_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_adr     (i_adr),
        .i_dat     (i_dat),
        .i_ack     (i_ack),
        .i_err     (i_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_sel     (d_sel),
        .d_adr     (d_adr),
        .d_dat_i   (d_dat_i),
        .d_dat_o   (d_dat_o),
        .d_ack     (d_ack),
        .d_err     (d_err),
        .mem_adr   (mem_adr),
        .mem_dat_o (mem_dat_o),
        .mem_dat_i (mem_dat_i),
        .mem_en    (mem_en),
        .mem_we    (mem_we)
    );

    typedef struct {
        logic        port;
        logic [31:0] dat;
        logic        err;
    } resp_t;

    typedef struct {
        logic        port;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [31:0] exp_dat;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    resp_t sb_q[$];
    vec_t  vecs[15];
    int    checks = 0;
    int    errors = 0;

    logic [7:0] bank [NUM_LANES][2**DEF_MEM_AW];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Four byte-wide banks: synchronous write, read data only while en && ~we.
    always @(posedge clk) begin
        for (int k = 0; k < NUM_LANES; k++) begin
            if (mem_en[k] && mem_we[k]) bank[k][mem_adr] <= mem_dat_o[8*k +: 8];
        end
    end

    always_comb begin
        mem_dat_i = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (mem_en[k] && !mem_we[k]) mem_dat_i[8*k +: 8] = bank[k][mem_adr];
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time expired before the summary");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic port, input logic [31:0] dat, input logic err);
        resp_t r;
        r.port = port;
        r.dat  = dat;
        r.err  = err;
        sb_q.push_back(r);
    endtask

    // Every ack pops the oldest expected response; order of pushes encodes the grant order.
    always @(negedge clk) begin
        resp_t r;
        if (!rst && (i_ack || d_ack)) begin
            check("single_ack", 32'(i_ack & d_ack), 32'h0);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_ack: actual i_ack=%b d_ack=%b required no ack", i_ack, d_ack);
            end else begin
                r = sb_q.pop_front();
                check("ack_port", 32'(d_ack), 32'(r.port));
                check("ack_dat", d_ack ? d_dat_o : i_dat, r.dat);
                check("ack_err", 32'(d_ack ? d_err : i_err), 32'(r.err));
            end
        end
    end

    // Drives one request, checks the ACCESS-cycle bank signals and the ack latency.
    task automatic apply_stimulus(input logic port, input logic we, input logic [3:0] sel,
                                  input logic [31:0] adr, input logic [31:0] wdat,
                                  input int exp_lat, input string name);
        int         cycles = 0;
        logic       acked  = 1'b0;
        logic [3:0] any_en = 4'h0;
        logic       is_wr;
        is_wr = (port == PORT_D) && we;
        if (port == PORT_D) begin
            d_we    = we;
            d_sel   = sel;
            d_adr   = adr;
            d_dat_i = wdat;
            d_req   = 1'b1;
        end else begin
            i_adr = adr;
            i_req = 1'b1;
        end
        while (!acked && cycles < 30) begin
            @(negedge clk);
            cycles++;
            any_en |= mem_en;
            if (exp_lat > 1 && cycles == exp_lat - 1) begin
                check({name, "_mem_en"}, 32'(mem_en), (port == PORT_D) ? 32'(sel) : 32'hF);
                check({name, "_mem_we"}, 32'(mem_we), is_wr ? 32'(sel) : 32'h0);
                check({name, "_mem_adr"}, 32'(mem_adr), 32'(adr[15:2]));
                check({name, "_mem_dat_o"}, mem_dat_o, is_wr ? wdat : 32'h0);
            end
            acked = (port == PORT_D) ? d_ack : i_ack;
        end
        check({name, "_latency"}, 32'(cycles), 32'(exp_lat));
        if (exp_lat == 1) check({name, "_no_bank_en"}, 32'(any_en), 32'h0);
        if (port == PORT_D) d_req = 1'b0;
        else                i_req = 1'b0;
    endtask

    task automatic check_output(input string name);
        check({name, "_acks"}, 32'({i_ack, d_ack}), 32'h0);
        check({name, "_mem_en"}, 32'(mem_en), 32'h0);
        check({name, "_mem_we"}, 32'(mem_we), 32'h0);
    endtask

    initial begin
        rst     = 1'b1;
        i_req   = 1'b1;
        i_adr   = 32'h0;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_sel   = 4'hF;
        d_adr   = 32'h4;
        d_dat_i = 32'h0;
        for (int k = 0; k < NUM_LANES; k++) begin
            for (int a = 0; a < 2**DEF_MEM_AW; a++) bank[k][a] = 8'h00;
        end

        //          port    we    sel    adr            wdat           exp_dat        err   lat
        vecs[0]  = '{PORT_D, 1'b1, 4'hF, 32'h0000_0010, 32'hDEADBEEF, 32'h0000_0000, 1'b0, 2};
        vecs[1]  = '{PORT_D, 1'b1, 4'h2, 32'h0000_0010, 32'h0000AB00, 32'h0000_0000, 1'b0, 2};
        vecs[2]  = '{PORT_I, 1'b0, 4'hF, 32'h0000_0010, 32'h0,        32'hDEADABEF, 1'b0, 2};
        vecs[3]  = '{PORT_D, 1'b0, 4'h1, 32'h0000_0010, 32'h0,        32'h0000_00EF, 1'b0, 2};
        vecs[4]  = '{PORT_D, 1'b1, 4'h0, 32'h0000_0020, 32'h12345678, 32'h0000_0000, 1'b0, 2};
        vecs[5]  = '{PORT_D, 1'b0, 4'hF, 32'h0000_0020, 32'h0,        32'h0000_0000, 1'b0, 2};
        vecs[6]  = '{PORT_D, 1'b1, 4'hC, 32'h0000_FFFC, 32'hCAFEF00D, 32'h0000_0000, 1'b0, 2};
        vecs[7]  = '{PORT_D, 1'b0, 4'hF, 32'h0000_FFFE, 32'h0,        32'hCAFE_0000, 1'b0, 2};
        vecs[8]  = '{PORT_I, 1'b0, 4'hF, 32'h0000_FFFC, 32'h0,        32'hCAFE_0000, 1'b0, 2};
        vecs[9]  = '{PORT_D, 1'b0, 4'hF, 32'h0001_0000, 32'h0,        32'h0000_0000, 1'b1, 1};
        vecs[10] = '{PORT_I, 1'b0, 4'hF, 32'h0000_0002, 32'h0,        32'h0000_0000, 1'b1, 1};
        vecs[11] = '{PORT_I, 1'b0, 4'hF, 32'h8000_0010, 32'h0,        32'h0000_0000, 1'b1, 1};
        vecs[12] = '{PORT_D, 1'b1, 4'hF, 32'h0001_0010, 32'h11111111, 32'h0000_0000, 1'b1, 1};
        vecs[13] = '{PORT_D, 1'b0, 4'hF, 32'h0000_0010, 32'h0,        32'hDEADABEF, 1'b0, 2};
        vecs[14] = '{PORT_D, 1'b0, 4'h6, 32'h0000_0010, 32'h0,        32'h00ADAB00, 1'b0, 2};

        repeat (3) begin
            @(negedge clk);
            check_output("reset");
        end
        check("reset_i_dat", i_dat, 32'h0);
        check("reset_d_dat_o", d_dat_o, 32'h0);
        check("reset_mem_adr", 32'(mem_adr), 32'h0);
        check("reset_mem_dat_o", mem_dat_o, 32'h0);
        check("reset_errs", 32'({i_err, d_err}), 32'h0);

        // Both ports pending at release: instruction port wins first.
        rst = 1'b0;
        push(PORT_I, 32'h0, 1'b0);
        push(PORT_D, 32'h0, 1'b0);
        fork
            apply_stimulus(PORT_I, 1'b0, 4'hF, 32'h0, 32'h0, 2, "boot_i");
            apply_stimulus(PORT_D, 1'b0, 4'hF, 32'h4, 32'h0, 5, "boot_d");
        join

        foreach (vecs[n]) begin
            @(negedge clk);
            push(vecs[n].port, vecs[n].exp_dat, vecs[n].exp_err);
            apply_stimulus(vecs[n].port, vecs[n].we, vecs[n].sel, vecs[n].adr, vecs[n].wdat,
                           vecs[n].exp_lat, $sformatf("vec%0d", n));
        end

        // Both ports requesting back to back: I, D, I, D with acks 3 cycles apart.
        @(negedge clk);
        push(PORT_I, 32'hDEADABEF, 1'b0);
        push(PORT_D, 32'hCAFE0000, 1'b0);
        push(PORT_I, 32'hCAFE0000, 1'b0);
        push(PORT_D, 32'hDEADABEF, 1'b0);
        fork
            begin
                apply_stimulus(PORT_I, 1'b0, 4'hF, 32'h10, 32'h0, 2, "rr_i0");
                apply_stimulus(PORT_I, 1'b0, 4'hF, 32'hFFFC, 32'h0, 6, "rr_i1");
            end
            begin
                apply_stimulus(PORT_D, 1'b0, 4'hF, 32'hFFFC, 32'h0, 5, "rr_d0");
                apply_stimulus(PORT_D, 1'b0, 4'hF, 32'h10, 32'h0, 6, "rr_d1");
            end
        join

        // Reset in the middle of a write's ACCESS cycle.
        @(negedge clk);
        d_we    = 1'b1;
        d_sel   = 4'hF;
        d_adr   = 32'h40;
        d_dat_i = 32'h55555555;
        d_req   = 1'b1;
        @(negedge clk);
        check("abort_pre_mem_en", 32'(mem_en), 32'hF);
        check("abort_pre_mem_we", 32'(mem_we), 32'hF);
        #2 rst = 1'b1;
        #1;
        check("abort_async_mem_en", 32'(mem_en), 32'h0);
        check("abort_async_mem_we", 32'(mem_we), 32'h0);
        check("abort_async_mem_dat_o", mem_dat_o, 32'h0);
        d_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("abort_no_ack", 32'({i_ack, d_ack}), 32'h0);
        end
        push(PORT_D, 32'hDEADABEF, 1'b0);
        apply_stimulus(PORT_D, 1'b0, 4'hF, 32'h10, 32'h0, 2, "post_abort");

        @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arb_ctrl.md
Name: mem_arb_ctrl

Overview:
Controller and two-port arbiter for the 32-bit on-chip RAM, which is built from four byte-wide bank instances (14-bit word address, en/we per bank, read data driven only while en && ~we).
It shares the RAM between the instruction-fetch port (read-only) and the data port (read/write with byte selects).
It sequences every access as a fixed three-state transaction with registered read data.
The block sits between the CPU bus ports and the four RAM banks.

Parameters:
MEM_AW, 14, word-address width presented to the banks (RAM = 2^MEM_AW words).
BASE_HI, 16'h0000, required value of address bits [31:MEM_AW+2]; any other value is out of range.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
i_req  in  1  instruction read request; held until i_ack.
i_adr  in  32  instruction byte address.
i_dat  out  32  instruction read data, valid while i_ack=1.
i_ack  out  1  one-cycle completion strobe.
i_err  out  1  error qualifier, valid with i_ack.
d_req  in  1  data request; held until d_ack.
d_we  in  1  1 = write, 0 = read.
d_sel  in  4  byte-lane enables; lane k = bits [8k+7:8k].
d_adr  in  32  data byte address; bits [1:0] ignored.
d_dat_i  in  32  write data.
d_dat_o  out  32  read data, valid while d_ack=1.
d_ack  out  1  one-cycle completion strobe.
d_err  out  1  error qualifier, valid with d_ack.
mem_adr  out  MEM_AW  word address to all banks.
mem_dat_o  out  32  write data to the banks; lane k feeds bank k.
mem_dat_i  in  32  read data from the banks; lane k comes from bank k.
mem_en  out  4  per-bank enable.
mem_we  out  4  per-bank write enable.

Behaviour:
- Reset values (async on rst): state=IDLE; last_grant=DATA; all acks, errs, mem_en, mem_we = 0; mem_adr, mem_dat_o, i_dat, d_dat_o = 0. The same values hold throughout reset.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. The error path is IDLE -> RESP.
- IDLE:
  - If no request is pending, stay in IDLE.
  - If exactly one request is pending, grant it.
  - If both are pending, grant the port that is not last_grant.
  - On grant, latch port id, address, we, sel and write data, and update last_grant.
  - Instruction access: sel is fixed at 4'b1111, we=0.
  - Error check: error if adr[31:MEM_AW+2] != BASE_HI, or if the access is an instruction access with i_adr[1:0] != 0. On error, set err_r and go to RESP.
  - Otherwise go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_adr = latched adr[MEM_AW+1:2].
  - mem_en = sel.
  - mem_we = we ? sel : 0.
  - mem_dat_o = write data on a write, 0 otherwise.
  - On a read, capture mem_dat_i into rdata at the end of the cycle, with unselected lanes forced to 0.
- RESP (exactly 1 cycle):
  - Assert the granted port's ack. Its err = err_r.
  - Its dat output = rdata on a read; 0 on a write or an error.
  - mem_en = mem_we = 0.
- Outside ACCESS, mem_en, mem_we and mem_dat_o are all 0, so the controller never drives the banks outside an access.
- Latency: req in cycle 0 -> ack in cycle 2; error ack in cycle 1. Throughput: one access per 3 cycles.
- Requester rule: a requester drops req in the cycle after it sees ack. IDLE samples req in the cycle following RESP, so back-to-back requests from one port are legal.
- Round-robin: when both ports hold req continuously, grants alternate I, D, I, D...
- d_sel=0000 write: completes normally with ack and without enabling any bank.
- Requests arriving during ACCESS or RESP wait; they are never dropped.
- Reset mid-access: the FSM returns to IDLE immediately and mem_en/mem_we drop asynchronously. No ack is issued for the aborted access, and partially written bank contents are undefined.

Decomposition:
- Package mem_ctrl_pkg:
  - state enum {IDLE, ACCESS, RESP}
  - port-id constants PORT_I and PORT_D
  - NUM_LANES = 4
  - default MEM_AW
- Sub-module mem_rr_arb: two-way round-robin arbiter. Inputs are req[1:0] and an advance strobe; outputs are a one-hot grant and the last_grant register.

Test Plan:
1. Hold rst=1 for 3 cycles with both reqs=1 -> all acks, mem_en and mem_we stay 0. After release, the first grant is the instruction port.
2. Data write, d_adr=0x0000_0010, d_sel=1111, d_dat_i=0xDEADBEEF -> ACCESS cycle shows mem_adr=4, mem_en=1111, mem_we=1111, mem_dat_o=0xDEADBEEF. d_ack=1 and d_err=0 two cycles after req.
3. Then a byte write at 0x10 with sel=0010 and data 0x0000AB00, followed by an instruction read of 0x10 -> i_dat=0xDEADABEF. A data read at 0x10 with sel=0001 -> d_dat_o=0x000000EF.
4. i_req and d_req held together for 4 accesses -> grant order I, D, I, D. Each ack lasts exactly 1 cycle, and acks are 3 cycles apart.
5. Out-of-range d_adr=0x0001_0000, then i_adr=0x0000_0002 -> ack and err=1 one cycle after req, with mem_en never asserted.
6. Assert rst during the ACCESS of a write -> mem_en and mem_we go to 0 without waiting for a clock edge, and no ack is issued. A subsequent read at a different address completes normally.
